request_handler: RTL and testbench

REQUEST_HANDLER -- requirements
Module: request_handler

---
 rtl/request_handler_pkg.sv | 20 ++
 rtl/request_handler_if.sv | 23 ++
 rtl/request_handler_onehot_decoder.sv | 15 +
 rtl/request_handler.sv | 92 +++++++++
 tb/tb_request_handler.sv | 137 +++++++++++++
 5 files changed

// File: rtl/request_handler_pkg.sv
// Shared definitions for the two-byte request handler: FSM encodings,
// device count and the address-valid test.
package request_handler_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      WAIT_ADDR    = 3'd1,
      DECODE       = 3'd2,
      WAIT_RELEASE = 3'd3
   } state_t;

   localparam int DEVICE_COUNT = 32;
   localparam int ADDR_LIMIT   = DEVICE_COUNT;
   localparam int SEL_W        = $clog2(DEVICE_COUNT);

   function automatic logic addr_valid(input logic [7:0] addr);
      return addr < 8'(ADDR_LIMIT);
   endfunction

endpackage

// File: rtl/request_handler_if.sv
// Byte input from the UART receiver and the decoded request outputs.
interface request_handler_if;
   import request_handler_pkg::*;

   logic                    enable;
   logic [7:0]              received_data;
   logic                    has_request;
   logic [7:0]              request;
   logic                    device_selected;
   logic [DEVICE_COUNT-1:0] device_selector;
   logic [2:0]              debug_state;

   modport master (
      output enable, received_data,
      input  has_request, request, device_selected, device_selector, debug_state
   );

   modport slave (
      input  enable, received_data,
      output has_request, request, device_selected, device_selector, debug_state
   );

endinterface

// File: rtl/request_handler_onehot_decoder.sv
// 5-bit address to 32-bit one-hot decode; all zeros when en is low.
module onehot_decoder
   import request_handler_pkg::*;
(
   input  logic [SEL_W-1:0]        addr,
   input  logic                    en,
   output logic [DEVICE_COUNT-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[addr] = 1'b1;
   end

endmodule

// File: rtl/request_handler.sv
// Two-byte request decoder: code byte, then device address byte, then a
// registered one-hot device select with a single-cycle request strobe.
module request_handler
   import request_handler_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
)
(
   input  logic             clock,
   input  logic             reset_n,
   request_handler_if.slave bus
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t                  state;
   logic [CNT_W-1:0]        idle_cnt;
   logic [7:0]              pend_code;
   logic [7:0]              pend_addr;
   logic                    has_request_r;
   logic [7:0]              request_r;
   logic                    selected_r;
   logic [DEVICE_COUNT-1:0] selector_r;
   logic [DEVICE_COUNT-1:0] dec_out;
   logic                    addr_ok;

   assign addr_ok = addr_valid(pend_addr);

   onehot_decoder u_dec (
      .addr   (pend_addr[SEL_W-1:0]),
      .en     (addr_ok),
      .onehot (dec_out)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state         <= IDLE;
         idle_cnt      <= '0;
         pend_code     <= '0;
         pend_addr     <= '0;
         has_request_r <= 1'b0;
         request_r     <= '0;
         selected_r    <= 1'b0;
         selector_r    <= '0;
      end else begin
         has_request_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.enable) begin
                  pend_code <= bus.received_data;
                  state     <= WAIT_ADDR;
               end
            end
            WAIT_ADDR: begin
               if (bus.enable) begin
                  pend_addr <= bus.received_data;
                  idle_cnt  <= '0;
                  state     <= DECODE;
               end else if (idle_cnt == CNT_LAST) begin
                  // Receiver went quiet mid-transaction: drop the code byte.
                  idle_cnt  <= '0;
                  pend_code <= '0;
                  state     <= IDLE;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            DECODE: begin
               selector_r <= dec_out;
               selected_r <= addr_ok;
               if (addr_ok) begin
                  request_r     <= pend_code;
                  has_request_r <= 1'b1;
               end
               state <= WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
               if (!bus.enable) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.has_request     = has_request_r;
   assign bus.request         = request_r;
   assign bus.device_selected = selected_r;
   assign bus.device_selector = selector_r;
   assign bus.debug_state     = state;

endmodule

// File: tb/tb_request_handler.sv
// Directed bench for request_handler: per-cycle vector table plus
// hand-written timeout and mid-transaction reset sequences.
module tb_request_handler;

   localparam int TO = 8;

   logic clock = 1'b0;
   logic reset_n;
   int   checks   = 0;
   int   failures = 0;

   request_handler_if bus ();

   request_handler #(.TIMEOUT_CYCLES(TO)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        rst_n;
      logic        en;
      logic [7:0]  data;
      logic [2:0]  st;
      logic        hr;
      logic [7:0]  req;
      logic        selv;
      logic [31:0] sel;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic e, input logic [7:0] d,
                      input logic [2:0] st, input logic hr, input logic [7:0] rq,
                      input logic sv, input logic [31:0] sl);
      vec_t v;
      v.rst_n = r; v.en = e; v.data = d; v.st = st;
      v.hr = hr; v.req = rq; v.selv = sv; v.sel = sl;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [2:0] st, input logic hr,
                            input logic [7:0] rq, input logic sv, input logic [31:0] sl);
      chk({tag, ".state"},    32'(bus.debug_state),     32'(st));
      chk({tag, ".has_req"},  32'(bus.has_request),     32'(hr));
      chk({tag, ".request"},  32'(bus.request),         32'(rq));
      chk({tag, ".selected"}, 32'(bus.device_selected), 32'(sv));
      chk({tag, ".selector"}, bus.device_selector,      sl);
   endtask

   task automatic cyc(input logic r, input logic e, input logic [7:0] d);
      reset_n           = r;
      bus.enable        = e;
      bus.received_data = d;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; bus.enable = 1'b0; bus.received_data = 8'h00;

      // Reset, then 0x01/0x05 decode
      add(0, 0, 8'h00, 0, 0, 8'h00, 0, 32'h0);
      add(0, 1, 8'h55, 0, 0, 8'h00, 0, 32'h0);
      add(1, 1, 8'h01, 1, 0, 8'h00, 0, 32'h0);
      add(1, 1, 8'h05, 2, 0, 8'h00, 0, 32'h0);
      add(1, 0, 8'h00, 3, 1, 8'h01, 1, 32'h0000_0020);
      add(1, 0, 8'h00, 0, 0, 8'h01, 1, 32'h0000_0020);
      // 0xFF/0x20 invalid address, enable held
      add(1, 1, 8'hFF, 1, 0, 8'h01, 1, 32'h0000_0020);
      add(1, 1, 8'h20, 2, 0, 8'h01, 1, 32'h0000_0020);
      add(1, 1, 8'h20, 3, 0, 8'h01, 0, 32'h0);
      for (int i = 0; i < 5; i++) add(1, 1, 8'h20, 3, 0, 8'h01, 0, 32'h0);
      add(1, 0, 8'h00, 0, 0, 8'h01, 0, 32'h0);
      // Back-to-back valid transactions, one enable-low gap
      add(1, 1, 8'h03, 1, 0, 8'h01, 0, 32'h0);
      add(1, 1, 8'h04, 2, 0, 8'h01, 0, 32'h0);
      add(1, 1, 8'hAA, 3, 1, 8'h03, 1, 32'h0000_0010);
      add(1, 0, 8'h00, 0, 0, 8'h03, 1, 32'h0000_0010);
      add(1, 1, 8'h09, 1, 0, 8'h03, 1, 32'h0000_0010);
      add(1, 1, 8'h1F, 2, 0, 8'h03, 1, 32'h0000_0010);
      add(1, 0, 8'h00, 3, 1, 8'h09, 1, 32'h8000_0000);
      add(1, 0, 8'h00, 0, 0, 8'h09, 1, 32'h8000_0000);

      for (int i = 0; i < vq.size(); i++) begin
         cyc(vq[i].rst_n, vq[i].en, vq[i].data);
         check_out($sformatf("vec%0d", i), vq[i].st, vq[i].hr, vq[i].req, vq[i].selv, vq[i].sel);
      end

      // Timeout: code byte then TO idle cycles abandons the transaction
      cyc(1, 1, 8'h03);
      for (int i = 0; i < TO - 1; i++) cyc(1, 0, 8'h00);
      check_out("to_before", 1, 0, 8'h09, 1, 32'h8000_0000);
      cyc(1, 0, 8'h00);
      check_out("to_expired", 0, 0, 8'h09, 1, 32'h8000_0000);
      cyc(1, 1, 8'h02);
      cyc(1, 1, 8'h1F);
      cyc(1, 0, 8'h00);
      check_out("to_next", 3, 1, 8'h02, 1, 32'h8000_0000);
      cyc(1, 0, 8'h00);

      // Counter restarts after a timeout: TO-1 idle cycles are tolerated
      cyc(1, 1, 8'h06);
      for (int i = 0; i < TO - 1; i++) cyc(1, 0, 8'h00);
      cyc(1, 1, 8'h02);
      chk("to_restart.state", 32'(bus.debug_state), 32'd2);
      cyc(1, 0, 8'h00);
      check_out("to_restart", 3, 1, 8'h06, 1, 32'h0000_0004);
      cyc(1, 0, 8'h00);

      // Reset while waiting for the address byte
      cyc(1, 1, 8'h11);
      chk("mid.state", 32'(bus.debug_state), 32'd1);
      cyc(0, 1, 8'h22);
      check_out("mid_reset", 0, 0, 8'h00, 0, 32'h0);
      cyc(1, 1, 8'h07);
      cyc(1, 1, 8'h00);
      cyc(1, 0, 8'h00);
      check_out("post_reset", 3, 1, 8'h07, 1, 32'h0000_0001);
      cyc(1, 0, 8'h00);
      check_out("post_reset_idle", 0, 0, 8'h07, 1, 32'h0000_0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
